mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between the CPU instruction-fetch port (I) and the load/store data port (D) of the MIPS minimal SOPC.
- Arbitrates with D-priority plus starvation protection, sequences each access through a request/acknowledge FSM, and raises a stall request to the pipeline control unit while any access is outstanding.

Parameters:
- ADDR_W, 32, address width (I, D and M buses).
- DATA_W, 32, data width.
- MAX_DSTREAK, 4, consecutive D grants allowed while i_req is pending before I is forced; range 1..15.
- TIMEOUT_CYCLES, 16, BUSY-cycle limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high (1 = RstEnable).
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched word; valid when i_ack=1.
- i_ack  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write.
- d_sel  in  4  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  load data; valid when d_ack=1.
- d_ack  out  1  one-cycle completion pulse.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable; 0 for I accesses.
- m_sel  out  4  byte enables; 4'hF for I accesses.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data.
- m_ack  in  1  memory completion; zero or more wait states.
- stall_req  out  1  stall request to pipeline control.
- bus_err  out  1  timeout pulse, aligned with the ack.

Behaviour:
- Reset:
  - Synchronous; state=IDLE.
  - m_req, m_we, i_ack, d_ack, bus_err = 0.
  - m_sel, m_addr, m_wdata, i_rdata, d_rdata = 0.
  - Streak counter and timeout counter = 0.
  - Reset mid-access abandons the transaction; a stray m_ack after reset is ignored.
- All outputs are registered, except stall_req.
- stall_req = (i_req & ~i_ack) | (d_req & ~d_ack), combinational.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise latch the winner's address, write data, we and sel into m_*, set m_req=1, record grant, go to BUSY.
- Arbitration:
  - Winner is D if d_req, except I wins when i_req=1 and streak==MAX_DSTREAK.
  - D granted while i_req=1: streak++ (saturating).
  - I granted, or i_req=0 at arbitration: streak=0.
- BUSY:
  - m_* held stable.
  - On m_ack=1: capture m_rdata into the granted port's rdata, drop m_req, assert that port's ack, go to DONE.
- DONE:
  - The ack is high for exactly this cycle; all requests are ignored; next state IDLE.
  - The requester must deassert req, or present a new access, on the cycle after its ack.
- Latency with a zero-wait memory:
  - req sampled at edge N, m_req high in cycle N+1, ack in cycle N+2, next arbitration at edge N+3.
  - An access therefore occupies 3 cycles, +1 per wait state.
- Edge cases:
  - Requester dropping req while granted does not abort; the ack still pulses.
  - m_ack in IDLE or DONE is ignored.
  - rdata holds its value between acks; write acks leave d_rdata unchanged.
  - i_req and d_req rising together resolve by the arbitration rule.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in BUSY.
  - If it reaches TIMEOUT_CYCLES with no m_ack: drop m_req, assert the granted ack with rdata=0, pulse bus_err the same cycle, go to DONE.
  - The counter clears on BUSY entry.
- Undefined:
  - BUSY waits indefinitely.
  - bus_err is tied to 0; the port is kept.

Decomposition:
- Shared package/include holds:
  - State encodings ARB_IDLE / ARB_BUSY / ARB_DONE.
  - Grant encodings GNT_I / GNT_D.
  - Streak and timeout counter widths.
  - Reset-value constants (reuse RstEnable / ZeroWord from the macros include).
- One sub-module, arb_pick:
  - Combinational winner select from i_req, d_req, streak, MAX_DSTREAK.
  - Unit-testable on its own.

Test Plan:
- Reset behaviour: rst=1 for 10 cycles, then release -> all outputs 0 and state IDLE; a pulse on m_ack has no effect.
- Single fetch: i_req, i_addr=32'h0000_0004, zero-wait memory returning 32'h3401_1100 -> m_req high 1 cycle later, then i_ack=1 with i_rdata=32'h3401_1100; stall_req high until the ack cycle.
- Simultaneous requests: D store (addr 32'h0000_0100, wdata 32'hDEAD_BEEF, sel 4'hF) and I fetch rise together -> D served first with m_we=1, I served in the next arbitration.
- Starvation: d_req held continuously with i_req pending, MAX_DSTREAK=4 -> exactly 4 D acks, then an I grant, then streak back to 0.
- Wait states and mid-transaction reset: memory acks after 3 wait states -> ack 5 cycles after req is sampled; separately, rst during BUSY -> m_req=0 on the next edge and no ack is ever produced.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): memory never acks -> d_ack=1, bus_err=1, d_rdata=0 at BUSY cycle 16; without the macro, d_ack never asserts and bus_err stays 0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared encodings, counter widths and reset constants for mem_bus_arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int STREAK_W = 4;
    localparam int TMO_W    = 16;

    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// rtl/mem_bus_arbiter_arb_pick.sv - combinational I/D winner select, D-priority with starvation limit
module arb_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_DSTREAK = 4
) (
    input  logic                i_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                valid,
    output logic                gnt
);

    logic i_forced;

    assign i_forced = i_req && (streak == STREAK_W'(MAX_DSTREAK));
    assign valid    = i_req || d_req;
    assign gnt      = (d_req && !i_forced) ? GNT_D : GNT_I;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory bus between the fetch (I) and load/store (D) ports
// Optional bus timeout enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [3:0]        m_sel,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              stall_req,
    output logic              bus_err
);

    arb_state_t          state, state_nxt;
    logic                gnt, gnt_nxt;
    logic [STREAK_W-1:0] streak, streak_nxt;
    logic                pick_valid, pick_gnt;
    logic                m_req_nxt, m_we_nxt, i_ack_nxt, d_ack_nxt;
    logic [3:0]          m_sel_nxt;
    logic [ADDR_W-1:0]   m_addr_nxt;
    logic [DATA_W-1:0]   m_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
    logic                fin;
    logic [DATA_W-1:0]   fin_data;
`ifdef ARB_TIMEOUT_EN
    logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
    logic                bus_err_nxt;
`endif

    arb_pick #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_arb_pick (
        .i_req  (i_req),
        .d_req  (d_req),
        .streak (streak),
        .valid  (pick_valid),
        .gnt    (pick_gnt)
    );

    assign stall_req = (i_req && !i_ack) || (d_req && !d_ack);

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        streak_nxt  = streak;
        m_req_nxt   = m_req;
        m_we_nxt    = m_we;
        m_sel_nxt   = m_sel;
        m_addr_nxt  = m_addr;
        m_wdata_nxt = m_wdata;
        i_rdata_nxt = i_rdata;
        d_rdata_nxt = d_rdata;
        i_ack_nxt   = 1'b0;
        d_ack_nxt   = 1'b0;
        fin         = 1'b0;
        fin_data    = m_rdata;
`ifdef ARB_TIMEOUT_EN
        tmo_nxt     = tmo_cnt;
        bus_err_nxt = 1'b0;
`endif
        case (state)
            ARB_IDLE: begin
                // Streak only grows while a fetch is actually being held off.
                if (pick_valid && pick_gnt == GNT_D && i_req)
                    streak_nxt = (streak == '1) ? streak : streak + 1'b1;
                else
                    streak_nxt = '0;
                if (pick_valid) begin
                    state_nxt = ARB_BUSY;
                    gnt_nxt   = pick_gnt;
                    m_req_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    tmo_nxt   = '0;
`endif
                    if (pick_gnt == GNT_D) begin
                        m_we_nxt    = d_we;
                        m_sel_nxt   = d_sel;
                        m_addr_nxt  = d_addr;
                        m_wdata_nxt = d_wdata;
                    end else begin
                        m_we_nxt    = 1'b0;
                        m_sel_nxt   = 4'hF;
                        m_addr_nxt  = i_addr;
                        m_wdata_nxt = '0;
                    end
                end
            end
            ARB_BUSY: begin
                if (m_ack) begin
                    fin = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    fin         = 1'b1;
                    fin_data    = '0;
                    bus_err_nxt = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
`endif
                if (fin) begin
                    state_nxt = ARB_DONE;
                    m_req_nxt = 1'b0;
                    if (gnt == GNT_I) begin
                        i_ack_nxt   = 1'b1;
                        i_rdata_nxt = fin_data;
                    end else begin
                        d_ack_nxt = 1'b1;
                        if (!m_we)
                            d_rdata_nxt = fin_data;
                    end
                end
            end
            ARB_DONE: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state   <= ARB_IDLE;
            gnt     <= GNT_I;
            streak  <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_sel   <= 4'h0;
            m_addr  <= '0;
            m_wdata <= DATA_W'(ZERO_WORD);
            i_rdata <= DATA_W'(ZERO_WORD);
            d_rdata <= DATA_W'(ZERO_WORD);
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            streak  <= streak_nxt;
            m_req   <= m_req_nxt;
            m_we    <= m_we_nxt;
            m_sel   <= m_sel_nxt;
            m_addr  <= m_addr_nxt;
            m_wdata <= m_wdata_nxt;
            i_rdata <= i_rdata_nxt;
            d_rdata <= d_rdata_nxt;
            i_ack   <= i_ack_nxt;
            d_ack   <= d_ack_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            tmo_cnt <= '0;
            bus_err <= 1'b0;
        end else begin
            tmo_cnt <= tmo_nxt;
            bus_err <= bus_err_nxt;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ack, d_req, d_we, d_ack;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_sel, m_sel;
    logic        m_req, m_we, m_ack, stall_req, bus_err;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int          vectors     = 0;
    int          miscompares = 0;
    int          mem_wait    = 0;
    int          busy_cnt    = 0;
    logic        stray_ack   = 1'b0;
    logic [31:0] mem_data    = 32'h0;

    always #5 clk = ~clk;

    // Memory model: acks after mem_wait wait states of m_req being held.
    always @(posedge clk) begin
        if (!m_req || m_ack) busy_cnt <= 0;
        else                 busy_cnt <= busy_cnt + 1;
    end
    assign m_ack   = stray_ack | (m_req && (busy_cnt == mem_wait));
    assign m_rdata = mem_data;

    mem_bus_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_sel     (d_sel),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_sel     (m_sel),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack),
        .stall_req (stall_req),
        .bus_err   (bus_err)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(i_ack || d_ack) && n < limit);
    endtask

    task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        d_req   = 1'b1;
        d_we    = we;
        d_sel   = 4'hF;
        d_addr  = addr;
        d_wdata = wdata;
    endtask

    initial begin
        int          n;
        int          acks;
        int          errs;
        logic [9:0]  seq;

        rst = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_sel = 4'h0; d_addr = '0; d_wdata = '0;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        check_vec("rst_m_req", m_req, 0);
        check_vec("rst_m_we", m_we, 0);
        check_vec("rst_m_sel", m_sel, 0);
        check_vec("rst_m_addr", m_addr, 0);
        check_vec("rst_m_wdata", m_wdata, 0);
        check_vec("rst_rdata", i_rdata | d_rdata, 0);
        check_vec("rst_acks", {bus_err, i_ack, d_ack, stall_req}, 0);
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        check_vec("stray_idle_m_req", m_req, 0);
        check_vec("stray_idle_ack", {i_ack, d_ack}, 0);

        // Single fetch, zero-wait memory
        mem_data = 32'h3401_1100;
        i_req = 1'b1; i_addr = 32'h0000_0004;
        #1 check_vec("fetch_stall_req", stall_req, 1);
        tick();
        check_vec("fetch_m_req", m_req, 1);
        check_vec("fetch_m_addr", m_addr, 32'h0000_0004);
        check_vec("fetch_m_we_sel", {m_we, m_sel}, 5'h0F);
        check_vec("fetch_no_ack_yet", i_ack, 0);
        check_vec("fetch_stall_busy", stall_req, 1);
        tick();
        check_vec("fetch_i_ack", i_ack, 1);
        check_vec("fetch_i_rdata", i_rdata, 32'h3401_1100);
        check_vec("fetch_stall_ack", stall_req, 0);
        check_vec("fetch_m_req_drop", m_req, 0);
        i_req = 1'b0;
        tick();
        check_vec("fetch_ack_pulse", i_ack, 0);
        check_vec("fetch_rdata_hold", i_rdata, 32'h3401_1100);

        // Simultaneous D store and I fetch: D first, I next
        mem_data = 32'h1111_2222;
        d_access(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        i_req = 1'b1; i_addr = 32'h0000_0008;
        tick();
        check_vec("sim_d_addr", m_addr, 32'h0000_0100);
        check_vec("sim_d_we", m_we, 1);
        check_vec("sim_d_wdata", m_wdata, 32'hDEAD_BEEF);
        tick();
        check_vec("sim_d_ack", {i_ack, d_ack}, 2'b01);
        check_vec("sim_write_rdata", d_rdata, 0);
        d_req = 1'b0;
        tick();
        tick();
        check_vec("sim_i_addr", m_addr, 32'h0000_0008);
        check_vec("sim_i_we_sel", {m_we, m_sel}, 5'h0F);
        tick();
        check_vec("sim_i_ack", {i_ack, d_ack}, 2'b10);
        check_vec("sim_i_rdata", i_rdata, 32'h1111_2222);
        i_req = 1'b0;
        tick();

        // Starvation: D held, I held; expect D D D D I D D D D I
        mem_data = 32'h5555_AAAA;
        d_access(1'b0, 32'h0000_0200, 32'h0);
        i_req = 1'b1; i_addr = 32'h0000_000C;
        seq = '0; acks = 0; n = 0;
        while (acks < 10 && n < 60) begin
            tick();
            n++;
            if (i_ack || d_ack) begin
                seq = {seq[8:0], i_ack};
                acks++;
            end
        end
        check_vec("starve_acks", acks, 10);
        check_vec("starve_order", seq, 10'b00001_00001);
        check_vec("starve_cycles", n, 29);
        check_vec("starve_d_rdata", d_rdata, 32'h5555_AAAA);
        d_req = 1'b0; i_req = 1'b0;
        tick();

        // Three wait states: ack 5 cycles after the request is presented
        mem_wait = 3; mem_data = 32'hCAFE_0001;
        d_access(1'b0, 32'h0000_0300, 32'h0);
        wait_ack(20, n);
        check_vec("wait3_latency", n, 5);
        check_vec("wait3_d_rdata", d_rdata, 32'hCAFE_0001);
        check_vec("wait3_m_addr_held", m_addr, 32'h0000_0300);
        d_req = 1'b0;
        tick();

        // Write ack leaves d_rdata unchanged
        mem_wait = 0; mem_data = 32'hFFFF_0000;
        d_access(1'b1, 32'h0000_0304, 32'h1234_5678);
        wait_ack(10, n);
        check_vec("write_latency", n, 2);
        check_vec("write_rdata_keep", d_rdata, 32'hCAFE_0001);
        d_req = 1'b0;
        tick();

        // Dropping req after grant still completes
        mem_wait = 2; mem_data = 32'h0BAD_F00D;
        d_access(1'b0, 32'h0000_0400, 32'h0);
        tick();
        d_req = 1'b0;
        wait_ack(10, n);
        check_vec("drop_req_ack", {n[7:0], d_ack}, {8'd3, 1'b1});
        check_vec("drop_req_rdata", d_rdata, 32'h0BAD_F00D);
        tick();

        // Reset during BUSY abandons the access
        mem_wait = 1000;
        d_access(1'b0, 32'h0000_0500, 32'h0);
        repeat (3) tick();
        check_vec("midrst_busy", m_req, 1);
        rst = 1'b1;
        tick();
        check_vec("midrst_m_req", m_req, 0);
        rst = 1'b0; d_req = 1'b0;
        tick();
        acks = 0;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        if (i_ack || d_ack) acks++;
        repeat (6) begin
            tick();
            if (i_ack || d_ack) acks++;
        end
        check_vec("midrst_no_ack", acks, 0);
        check_vec("midrst_rdata_cleared", d_rdata, 0);

        // Preload d_rdata so a timeout's zero read is visible
        mem_wait = 0; mem_data = 32'h7777_8888;
        d_access(1'b0, 32'h0000_0600, 32'h0);
        wait_ack(10, n);
        check_vec("preload_rdata", d_rdata, 32'h7777_8888);
        d_req = 1'b0;
        tick();

        // Memory never acks
        mem_wait = 1000;
        d_access(1'b0, 32'h0000_0604, 32'h0);
`ifdef ARB_TIMEOUT_EN
        wait_ack(40, n);
        check_vec("tmo_latency", n, 17);
        check_vec("tmo_ack_err", {d_ack, bus_err}, 2'b11);
        check_vec("tmo_rdata_zero", d_rdata, 0);
        d_req = 1'b0;
        tick();
        check_vec("tmo_err_pulse", {d_ack, bus_err}, 2'b00);
`else
        acks = 0; errs = 0;
        repeat (40) begin
            tick();
            if (i_ack || d_ack) acks++;
            if (bus_err) errs++;
        end
        check_vec("hang_no_ack", acks, 0);
        check_vec("hang_no_err", errs, 0);
        check_vec("hang_m_req", m_req, 1);
        d_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("hang_rst_m_req", m_req, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
